// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: drives one column low at a time, samples the synchronised
// row returns, debounces whole-keypad snapshots and reports a single held key one-hot.
module keypad_scanner_4x4 #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [15:0] keys,
   output logic        key_valid,
   output logic        key_pressed
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

   logic [3:0]    row_meta;
   logic [3:0]    row_sync;
   logic [DW-1:0] div;
   logic [1:0]    ci;
   logic [15:0]   scan;
   logic [15:0]   prev;
   logic [15:0]   snap;
   logic [CW-1:0] stable_cnt;
   logic [CW-1:0] cnt_next;
   logic          col_end;
   logic          scan_end;
   logic          accept;

   assign col      = ~(4'b0001 << ci);
   assign col_end  = (div == DW'(SCAN_DIV - 1));
   assign scan_end = col_end && (ci == 2'd3);

   // Snapshot as it will look after this edge: the current column's rows folded in,
   // so the last column is part of the debounced word on the same edge it is sampled.
   always_comb begin
      snap = scan;
      for (int r = 0; r < 4; r++) begin
         snap[{2'(r), ci}] = ~row_sync[r];
      end
   end

   always_comb begin
      cnt_next = CW'(1);
      if (snap == prev) begin
         if (stable_cnt == CW'(DEBOUNCE_SCANS)) begin
            cnt_next = stable_cnt;
         end else begin
            cnt_next = stable_cnt + 1'b1;
         end
      end
   end

   assign accept = (cnt_next == CW'(DEBOUNCE_SCANS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta <= 4'b1111;
         row_sync <= 4'b1111;
      end else begin
         row_meta <= row;
         row_sync <= row_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
         ci  <= 2'd0;
         scan <= '0;
      end else if (col_end) begin
         div  <= '0;
         ci   <= ci + 1'b1;
         scan <= snap;
      end else begin
         div <= div + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev        <= '0;
         stable_cnt  <= '0;
         keys        <= '0;
         key_valid   <= 1'b0;
         key_pressed <= 1'b0;
      end else begin
         key_pressed <= 1'b0;
         if (scan_end) begin
            prev       <= snap;
            stable_cnt <= cnt_next;
            if (accept) begin
               // Zero or multi-key (ghosting) snapshots both read as "no key".
               if ($onehot(snap)) begin
                  keys        <= snap;
                  key_valid   <= 1'b1;
                  key_pressed <= (snap != keys);
               end else begin
                  keys      <= '0;
                  key_valid <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Randomised scoreboard bench for keypad_scanner_4x4 with a behavioural keypad and
// a per-scan reference model of debounce and acceptance.
module tb_keypad_scanner_4x4;
   localparam int SD = 4;
   localparam int DB = 3;
   localparam int SP = 4 * SD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [15:0] keys;
   logic        key_valid;
   logic        key_pressed;
   logic [15:0] pressed = 16'h0000;

   keypad_scanner_4x4 #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
      .clk(clk), .rst_n(rst_n), .row(row), .col(col),
      .keys(keys), .key_valid(key_valid), .key_pressed(key_pressed)
   );

   always #5 clk = ~clk;

   // Passive keypad: a row reads low when a pressed key sits on a driven column.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[4*r+c] && !col[c]) row[r] = 1'b0;
   end

   int unsigned e_cnt;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) e_cnt <= 0;
      else        e_cnt <= e_cnt + 1;

   typedef struct {
      logic [15:0] k;
      logic        v;
      logic        p;
      int          scan;
   } ev_t;

   ev_t         q[$];
   logic [15:0] hist[$];
   int          nscan = 0;
   logic [15:0] m_keys = 16'h0;
   logic        m_valid = 1'b0;
   bit          mon_en = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, e_cnt);
      end
   endtask

   // Hold a key set for n whole scans; after each scan the model decides acceptance.
   task automatic hold(input logic [15:0] s, input int n);
      for (int i = 0; i < n; i++) begin
         bit same;
         pressed = s;
         nscan++;
         hist.push_back(s);
         if (hist.size() > DB) void'(hist.pop_front());
         same = (hist.size() == DB);
         foreach (hist[j]) if (hist[j] !== s) same = 1'b0;
         if (same) begin
            if ($countones(s) == 1) begin
               if (s != m_keys) q.push_back('{k: s, v: 1'b1, p: 1'b1, scan: nscan});
               m_keys  = s;
               m_valid = 1'b1;
            end else begin
               if (m_keys != 16'h0 || m_valid)
                  q.push_back('{k: 16'h0, v: 1'b0, p: 1'b0, scan: nscan});
               m_keys  = 16'h0;
               m_valid = 1'b0;
            end
         end
         repeat (SP) @(negedge clk);
      end
   endtask

   initial begin : monitor
      logic [15:0] last_k;
      logic        last_v;
      ev_t         ev;
      last_k = 16'h0;
      last_v = 1'b0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            last_k = 16'h0;
            last_v = 1'b0;
         end else begin
            chk("col_drive", {28'h0, col}, {28'h0, ~(4'b0001 << ((e_cnt / SD) % 4))});
            if (keys !== last_k || key_valid !== last_v || key_pressed !== 1'b0) begin
               if (q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_output: keys=%h valid=%b pressed=%b at edge %0d, nothing expected",
                           keys, key_valid, key_pressed, e_cnt);
               end else begin
                  ev = q.pop_front();
                  chk("keys", {16'h0, keys}, {16'h0, ev.k});
                  chk("key_valid", {31'h0, key_valid}, {31'h0, ev.v});
                  chk("key_pressed", {31'h0, key_pressed}, {31'h0, ev.p});
                  chk("update_edge", e_cnt, ev.scan * SP);
               end
               last_k = keys;
               last_v = key_valid;
            end
         end
      end
   end

   initial begin
      int k1, k2;
      // Reset held with a key down, clock running.
      pressed = 16'h0040;
      repeat (5) @(negedge clk);
      chk("rst_col", {28'h0, col}, 32'he);
      chk("rst_keys", {16'h0, keys}, 32'h0);
      chk("rst_valid", {31'h0, key_valid}, 32'h0);
      chk("rst_pressed", {31'h0, key_pressed}, 32'h0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      hold(16'h0040, 4);                        // held through reset release
      hold(16'h0000, 5);                        // release
      hold(16'h0100, 1); hold(16'h0000, 1);     // bounce
      hold(16'h0100, 1); hold(16'h0000, 1);
      hold(16'h0100, 1); hold(16'h0100, 4);
      hold(16'h0001, 4);
      hold(16'h8001, 4);                        // ghosting
      hold(16'h0001, 4);
      hold(16'h0002, 4);                        // key-to-key
      hold(16'h0800, 4);
      hold(16'h0040, 4);

      // Asynchronous reset mid-scan.
      repeat (6) @(negedge clk);
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("arst_col", {28'h0, col}, 32'he);
      chk("arst_keys", {16'h0, keys}, 32'h0);
      chk("arst_valid", {31'h0, key_valid}, 32'h0);
      chk("arst_pressed", {31'h0, key_pressed}, 32'h0);
      chk("arst_queue_empty", q.size(), 0);
      q.delete();
      hist.delete();
      nscan   = 0;
      m_keys  = 16'h0;
      m_valid = 1'b0;
      repeat (3) @(negedge clk);
      pressed = 16'h0000;
      rst_n   = 1'b1;
      mon_en  = 1'b1;

      for (int i = 0; i < 30; i++) begin
         k1 = $urandom_range(0, 15);
         k2 = (k1 + $urandom_range(1, 15)) % 16;
         case ($urandom_range(0, 3))
            0:       hold(16'h0000, $urandom_range(1, 5));
            1, 2:    hold(16'(1) << k1, $urandom_range(1, 5));
            default: hold((16'(1) << k1) | (16'(1) << k2), $urandom_range(1, 5));
         endcase
      end
      hold(16'h0000, 4);
      repeat (2) @(negedge clk);
      chk("final_queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
